// File: rtl/ad9783_pkg.sv
// ad9783_pkg: shared definitions for the AD9783 SPI scheduler.
//   - host command opcodes (cmd_addr_in[15:8])
//   - SPI word layout helper {rw, 2'b00, addr[4:0], data[7:0]}
//   - FSM state and transfer-source encodings
//   - register-init table played after reset (entry 0 data is replaced by SMP_DLY)
// Optional feature macro: AD9783_INIT_VERIFY_EN adds the readback state.
package ad9783_pkg;

  localparam logic [7:0]  OP_GET           = 8'h20;
  localparam logic [7:0]  OP_SET           = 8'h21;
  localparam logic [15:0] CMD_TIMEOUT_WORD = 16'hDEAD;

  localparam logic [7:0] AD9783_INIT_ADDR [0:7] = '{
    8'h05, 8'h02, 8'h0A, 8'h0E, 8'h00, 8'h00, 8'h00, 8'h00
  };
  localparam logic [7:0] AD9783_INIT_DATA [0:7] = '{
    8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00, 8'h00
  };

  typedef enum logic [3:0] {
    StRstHold,
    StRstRel,
    StInitLoad,
    StHostLoad,
    StIssue,
    StWaitBusy,
    StWaitDone,
    StIdle
`ifdef AD9783_INIT_VERIFY_EN
    , StVerifyLoad
`endif
  } state_e;

  // Which operation owns the transfer currently in ISSUE/WAIT_*.
  typedef enum logic [1:0] {
    SrcInit,
    SrcVerify,
    SrcHost
  } src_e;

  function automatic logic [15:0] spi_word(input logic       rw,
                                           input logic [4:0] addr,
                                           input logic [7:0] data);
    return {rw, 2'b00, addr, data};
  endfunction

endpackage

// File: rtl/ad9783_spi_phase_timer.sv
// ad9783_spi_phase_timer: per-phase watchdog for SPI handshakes.
//   clk_in, rst_in : clock, asynchronous active-high reset
//   clear_i        : restart the count (asserted on every phase entry)
//   en_i           : count while waiting in a phase
//   expired_o      : count has reached TIMEOUT; holds until cleared
module ad9783_spi_phase_timer #(
  parameter int unsigned TIMEOUT = 1023
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic clear_i,
  input  logic en_i,
  output logic expired_o
);

  localparam int unsigned    CntW  = $clog2(TIMEOUT + 1);
  localparam logic [CntW-1:0] Limit = CntW'(TIMEOUT);

  logic [CntW-1:0] cnt_q, cnt_d;

  assign expired_o = (cnt_q == Limit);

  always_comb begin
    cnt_d = cnt_q;
    if (clear_i) begin
      cnt_d = '0;
    end else if (en_i && !expired_o) begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/ad9783_spi_scheduler.sv
// ad9783_spi_scheduler: owns the AD9783 SPI control path.
// After reset it holds dac_rst_out high for RST_CYCLES, plays N_INIT init-table
// writes through the SPI master, then serves host get/set commands from a
// one-deep pending slot.
//   clk_in, rst_in          : clock, asynchronous active-high reset
//   cmd_trig_in/addr/data   : host command strobe; addr[15:8] 0x20 get, 0x21 set
//   cmd_data_out/done_out   : read word and one-cycle completion of a host command
//   busy_out, init_done_out : FSM not idle / init table finished (sticky)
//   pend_ovf_out            : sticky, host command dropped (slot full)
//   timeout_out             : sticky, an SPI phase exceeded TIMEOUT cycles
//   init_err_out            : sticky init readback mismatch (verify builds only)
//   dac_rst_out             : DAC RESET pin
//   spi_*                   : handshake with the 16-bit SPI master
// Macro AD9783_INIT_VERIFY_EN: read back every init write and flag mismatches.
module ad9783_spi_scheduler
  import ad9783_pkg::*;
#(
  parameter int unsigned RST_CYCLES = 255,
  parameter int unsigned N_INIT     = 4,
  parameter logic [7:0]  SMP_DLY    = 8'h00,
  parameter int unsigned TIMEOUT    = 1023
) (
  input  logic        clk_in,
  input  logic        rst_in,
  input  logic        cmd_trig_in,
  input  logic [15:0] cmd_addr_in,
  input  logic [15:0] cmd_data_in,
  output logic [15:0] cmd_data_out,
  output logic        cmd_done_out,
  output logic        busy_out,
  output logic        init_done_out,
  output logic        pend_ovf_out,
  output logic        timeout_out,
  output logic        init_err_out,
  output logic        dac_rst_out,
  output logic        spi_trigger_out,
  output logic [15:0] spi_data_out,
  input  logic        spi_ready_in,
  input  logic [15:0] spi_rdata_in
);

  localparam logic [3:0] NInit = 4'(N_INIT);

  state_e      state_q, state_d;
  src_e        src_q, src_d;
  logic [7:0]  rst_cnt_q, rst_cnt_d;
  logic [3:0]  idx_q, idx_d;
  logic [15:0] spi_data_q, spi_data_d;
  logic [15:0] cmd_data_q, cmd_data_d;
  logic        cmd_done_q, cmd_done_d;
  logic        init_done_q, init_done_d;
  logic        timeout_q, timeout_d;
  logic        dac_rst_q, dac_rst_d;

  // Command being served, copied out of the slot so a new trig can refill it.
  logic        hold_rw_q, hold_rw_d;
  logic [4:0]  hold_addr_q, hold_addr_d;
  logic [7:0]  hold_data_q, hold_data_d;

  logic        pend_full_q, pend_full_d;
  logic        pend_rw_q, pend_rw_d;
  logic [4:0]  pend_addr_q, pend_addr_d;
  logic [7:0]  pend_data_q, pend_data_d;
  logic        pend_ovf_q, pend_ovf_d;

`ifdef AD9783_INIT_VERIFY_EN
  logic [4:0]  cur_addr_q, cur_addr_d;
  logic [7:0]  cur_data_q, cur_data_d;
  logic        init_err_q, init_err_d;
`endif

  logic       cmd_valid, drain;
  logic [7:0] tbl_addr, tbl_data;
  logic [3:0] idx_inc;
  logic       phase_wait, phase_clear, phase_expired;
  logic       phase_end, phase_to, advance;
  logic       unused_bits;

  assign cmd_valid = cmd_trig_in &&
                     ((cmd_addr_in[15:8] == OP_GET) || (cmd_addr_in[15:8] == OP_SET));
  assign drain     = (state_q == StIdle) && pend_full_q;
  assign tbl_addr  = AD9783_INIT_ADDR[idx_q[2:0]];
  assign tbl_data  = (idx_q == 4'd0) ? SMP_DLY : AD9783_INIT_DATA[idx_q[2:0]];
  assign idx_inc   = idx_q + 4'd1;
  assign unused_bits = ^{cmd_data_in[15:8], cmd_addr_in[7:5], tbl_addr[7:5]};

  assign phase_wait  = (state_q == StIssue) || (state_q == StWaitBusy) ||
                       (state_q == StWaitDone);
  assign phase_clear = (state_d != state_q);

  ad9783_spi_phase_timer #(
    .TIMEOUT(TIMEOUT)
  ) u_phase_timer (
    .clk_in   (clk_in),
    .rst_in   (rst_in),
    .clear_i  (phase_clear),
    .en_i     (phase_wait),
    .expired_o(phase_expired)
  );

  // Pending slot: a trig is accepted when the slot is empty or drains this cycle.
  always_comb begin
    pend_full_d = pend_full_q;
    pend_rw_d   = pend_rw_q;
    pend_addr_d = pend_addr_q;
    pend_data_d = pend_data_q;
    pend_ovf_d  = pend_ovf_q;
    if (drain) begin
      pend_full_d = 1'b0;
    end
    if (cmd_valid) begin
      if (!pend_full_q || drain) begin
        pend_full_d = 1'b1;
        pend_rw_d   = (cmd_addr_in[15:8] == OP_GET);
        pend_addr_d = cmd_addr_in[4:0];
        pend_data_d = cmd_data_in[7:0];
      end else begin
        pend_ovf_d  = 1'b1;
      end
    end
  end

  always_comb begin
    state_d     = state_q;
    src_d       = src_q;
    rst_cnt_d   = rst_cnt_q;
    idx_d       = idx_q;
    spi_data_d  = spi_data_q;
    cmd_data_d  = cmd_data_q;
    cmd_done_d  = 1'b0;
    init_done_d = init_done_q;
    timeout_d   = timeout_q;
    dac_rst_d   = dac_rst_q;
    hold_rw_d   = hold_rw_q;
    hold_addr_d = hold_addr_q;
    hold_data_d = hold_data_q;
    phase_end   = 1'b0;
    phase_to    = 1'b0;
    advance     = 1'b0;
`ifdef AD9783_INIT_VERIFY_EN
    cur_addr_d  = cur_addr_q;
    cur_data_d  = cur_data_q;
    init_err_d  = init_err_q;
`endif

    unique case (state_q)
      StRstHold: begin
        if (rst_cnt_q <= 8'd1) begin
          dac_rst_d = 1'b0;
          state_d   = StRstRel;
        end else begin
          rst_cnt_d = rst_cnt_q - 8'd1;
        end
      end
      StRstRel: begin
        idx_d   = 4'd0;
        state_d = StInitLoad;
      end
      StInitLoad: begin
        spi_data_d = spi_word(1'b0, tbl_addr[4:0], tbl_data);
        src_d      = SrcInit;
        state_d    = StIssue;
`ifdef AD9783_INIT_VERIFY_EN
        cur_addr_d = tbl_addr[4:0];
        cur_data_d = tbl_data;
`endif
      end
`ifdef AD9783_INIT_VERIFY_EN
      StVerifyLoad: begin
        spi_data_d = spi_word(1'b1, cur_addr_q, 8'h00);
        src_d      = SrcVerify;
        state_d    = StIssue;
      end
`endif
      StHostLoad: begin
        spi_data_d = spi_word(hold_rw_q, hold_addr_q, hold_rw_q ? 8'h00 : hold_data_q);
        src_d      = SrcHost;
        state_d    = StIssue;
      end
      StIssue: begin
        if (phase_expired) begin
          phase_end = 1'b1;
          phase_to  = 1'b1;
        end else if (spi_ready_in) begin
          state_d = StWaitBusy;
        end
      end
      StWaitBusy: begin
        if (phase_expired) begin
          phase_end = 1'b1;
          phase_to  = 1'b1;
        end else if (!spi_ready_in) begin
          state_d = StWaitDone;
        end
      end
      StWaitDone: begin
        if (phase_expired) begin
          phase_end = 1'b1;
          phase_to  = 1'b1;
        end else if (spi_ready_in) begin
          phase_end = 1'b1;
        end
      end
      StIdle: begin
        if (pend_full_q) begin
          hold_rw_d   = pend_rw_q;
          hold_addr_d = pend_addr_q;
          hold_data_d = pend_data_q;
          state_d     = StHostLoad;
        end
      end
      default: state_d = StRstHold;
    endcase

    // Transfer finished (normally or by timeout): route by owner.
    if (phase_end) begin
      if (phase_to) begin
        timeout_d = 1'b1;
      end
      case (src_q)
        SrcHost: begin
          cmd_done_d = 1'b1;
          cmd_data_d = phase_to ? CMD_TIMEOUT_WORD : spi_rdata_in;
          state_d    = StIdle;
        end
`ifdef AD9783_INIT_VERIFY_EN
        SrcInit: begin
          // A timed-out write is skipped without a readback.
          if (phase_to) begin
            advance = 1'b1;
          end else begin
            state_d = StVerifyLoad;
          end
        end
        SrcVerify: begin
          if (phase_to || (spi_rdata_in[7:0] != cur_data_q)) begin
            init_err_d = 1'b1;
          end
          advance = 1'b1;
        end
`endif
        default: advance = 1'b1;
      endcase
    end

    if (advance) begin
      idx_d = idx_inc;
      if (idx_inc == NInit) begin
        init_done_d = 1'b1;
        state_d     = StIdle;
      end else begin
        state_d = StInitLoad;
      end
    end
  end

  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q     <= StRstHold;
      src_q       <= SrcInit;
      rst_cnt_q   <= 8'(RST_CYCLES);
      idx_q       <= 4'd0;
      spi_data_q  <= 16'h0000;
      cmd_data_q  <= 16'h0000;
      cmd_done_q  <= 1'b0;
      init_done_q <= 1'b0;
      timeout_q   <= 1'b0;
      dac_rst_q   <= 1'b1;
      hold_rw_q   <= 1'b0;
      hold_addr_q <= 5'd0;
      hold_data_q <= 8'h00;
      pend_full_q <= 1'b0;
      pend_rw_q   <= 1'b0;
      pend_addr_q <= 5'd0;
      pend_data_q <= 8'h00;
      pend_ovf_q  <= 1'b0;
`ifdef AD9783_INIT_VERIFY_EN
      cur_addr_q  <= 5'd0;
      cur_data_q  <= 8'h00;
      init_err_q  <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      src_q       <= src_d;
      rst_cnt_q   <= rst_cnt_d;
      idx_q       <= idx_d;
      spi_data_q  <= spi_data_d;
      cmd_data_q  <= cmd_data_d;
      cmd_done_q  <= cmd_done_d;
      init_done_q <= init_done_d;
      timeout_q   <= timeout_d;
      dac_rst_q   <= dac_rst_d;
      hold_rw_q   <= hold_rw_d;
      hold_addr_q <= hold_addr_d;
      hold_data_q <= hold_data_d;
      pend_full_q <= pend_full_d;
      pend_rw_q   <= pend_rw_d;
      pend_addr_q <= pend_addr_d;
      pend_data_q <= pend_data_d;
      pend_ovf_q  <= pend_ovf_d;
`ifdef AD9783_INIT_VERIFY_EN
      cur_addr_q  <= cur_addr_d;
      cur_data_q  <= cur_data_d;
      init_err_q  <= init_err_d;
`endif
    end
  end

  // Trigger is combinational so it fires in the first ISSUE cycle with ready high.
  assign spi_trigger_out = (state_q == StIssue) && spi_ready_in && !phase_expired;
  assign spi_data_out    = spi_data_q;
  assign cmd_data_out    = cmd_data_q;
  assign cmd_done_out    = cmd_done_q;
  assign busy_out        = (state_q != StIdle);
  assign init_done_out   = init_done_q;
  assign pend_ovf_out    = pend_ovf_q;
  assign timeout_out     = timeout_q;
  assign dac_rst_out     = dac_rst_q;
`ifdef AD9783_INIT_VERIFY_EN
  assign init_err_out    = init_err_q;
`else
  assign init_err_out    = 1'b0;
`endif

endmodule

// File: tb/tb_ad9783_spi_scheduler.sv
// Directed bench for ad9783_spi_scheduler with a behavioural SPI master
// (20-cycle transfers, register file, reg 0x02 reads back 0xFF).
module tb_ad9783_spi_scheduler;

`ifdef AD9783_INIT_VERIFY_EN
  localparam int INIT_TRIGS = 8;
  localparam logic EXP_INIT_ERR = 1'b1;
`else
  localparam int INIT_TRIGS = 4;
  localparam logic EXP_INIT_ERR = 1'b0;
`endif

  logic        clk_in = 1'b0;
  logic        rst_in = 1'b1;
  logic        cmd_trig_in = 1'b0;
  logic [15:0] cmd_addr_in = 16'h0000;
  logic [15:0] cmd_data_in = 16'h0000;
  logic [15:0] cmd_data_out;
  logic        cmd_done_out, busy_out, init_done_out, pend_ovf_out;
  logic        timeout_out, init_err_out, dac_rst_out, spi_trigger_out;
  logic [15:0] spi_data_out;
  logic        spi_ready_in;
  logic [15:0] spi_rdata_in;

  always #5 clk_in = ~clk_in;

  ad9783_spi_scheduler dut (
    .clk_in         (clk_in),
    .rst_in         (rst_in),
    .cmd_trig_in    (cmd_trig_in),
    .cmd_addr_in    (cmd_addr_in),
    .cmd_data_in    (cmd_data_in),
    .cmd_data_out   (cmd_data_out),
    .cmd_done_out   (cmd_done_out),
    .busy_out       (busy_out),
    .init_done_out  (init_done_out),
    .pend_ovf_out   (pend_ovf_out),
    .timeout_out    (timeout_out),
    .init_err_out   (init_err_out),
    .dac_rst_out    (dac_rst_out),
    .spi_trigger_out(spi_trigger_out),
    .spi_data_out   (spi_data_out),
    .spi_ready_in   (spi_ready_in),
    .spi_rdata_in   (spi_rdata_in)
  );

  // ---------------- SPI master model ----------------
  logic        stuck = 1'b0;
  logic        rd_force = 1'b0;
  logic [15:0] rd_val = 16'h0000;
  logic        m_ready;
  logic [5:0]  m_cnt;
  logic [15:0] m_word, m_rdata, m_resp;
  logic [7:0]  regs [0:31];

  always_comb begin
    m_resp = 16'h0000;
    if (m_word[15]) begin
      if (rd_force) m_resp = rd_val;
      else if (m_word[12:8] == 5'd2) m_resp = 16'h00FF;
      else m_resp = {8'h00, regs[m_word[12:8]]};
    end
  end

  always @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      m_ready <= 1'b1;
      m_cnt   <= 6'd0;
      m_word  <= 16'h0000;
      m_rdata <= 16'h0000;
      for (int i = 0; i < 32; i++) regs[i] <= 8'h00;
    end else if (m_cnt != 6'd0) begin
      m_cnt <= m_cnt - 6'd1;
      if (m_cnt == 6'd1) begin
        m_ready <= 1'b1;
        m_rdata <= m_resp;
      end
    end else if (spi_trigger_out && m_ready && !stuck) begin
      m_ready <= 1'b0;
      m_cnt   <= 6'd20;
      m_word  <= spi_data_out;
      if (!spi_data_out[15]) regs[spi_data_out[12:8]] <= spi_data_out[7:0];
    end
  end

  assign spi_ready_in = m_ready;
  assign spi_rdata_in = m_rdata;

  // ---------------- monitor ----------------
  int          cyc = 0;
  int          trig_cnt = 0;
  int          done_cnt = 0;
  int          done_busy = 0;
  int          last_trig_cyc = 0;
  logic [15:0] done_data = 16'h0000;
  logic [15:0] trig_log [$];

  always @(posedge clk_in) cyc <= cyc + 1;

  always @(negedge clk_in) begin
    if (spi_trigger_out) begin
      trig_cnt++;
      last_trig_cyc = cyc;
      trig_log.push_back(spi_data_out);
    end
    if (cmd_done_out) begin
      done_cnt++;
      done_data = cmd_data_out;
      if (busy_out) done_busy++;
    end
  end

  // ---------------- checking ----------------
  int n_total = 0;
  int n_bad = 0;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] log_at(input int i);
    if (i < trig_log.size()) return trig_log[i];
    return 16'hXXXX;
  endfunction

  int cmd_cyc = 0;

  task automatic send_cmd(input logic [15:0] addr, input logic [15:0] data);
    @(negedge clk_in);
    cmd_trig_in = 1'b1;
    cmd_addr_in = addr;
    cmd_data_in = data;
    cmd_cyc     = cyc;
    @(negedge clk_in);
    cmd_trig_in = 1'b0;
  endtask

  task automatic wait_done(input int start, input int budget, input string tag);
    int n = 0;
    while (done_cnt <= start && n < budget) begin
      @(posedge clk_in); #1;
      n++;
    end
    check_eq(tag, 32'(done_cnt > start), 32'd1);
  endtask

  task automatic wait_cycles(input int n);
    for (int i = 0; i < n; i++) @(posedge clk_in);
    #1;
  endtask

  task automatic bring_up(input string tag);
    int n = 0;
    while (!init_done_out && n < 3000) begin
      @(posedge clk_in); #1;
      n++;
    end
    check_eq(tag, 32'(init_done_out), 32'd1);
  endtask

  logic [15:0] exp_init [0:7];
  int base, t0, d0, n;

  initial begin
`ifdef AD9783_INIT_VERIFY_EN
    exp_init = '{16'h0500, 16'h8500, 16'h0200, 16'h8200,
                 16'h0A00, 16'h8A00, 16'h0E00, 16'h8E00};
`else
    exp_init = '{16'h0500, 16'h0200, 16'h0A00, 16'h0E00,
                 16'h0000, 16'h0000, 16'h0000, 16'h0000};
`endif

    // Reset state
    @(negedge clk_in); @(negedge clk_in);
    check_eq("rst_dac", 32'(dac_rst_out), 32'd1);
    check_eq("rst_trig", 32'(spi_trigger_out), 32'd0);
    check_eq("rst_spi_data", 32'(spi_data_out), 32'h0);
    check_eq("rst_cmd_data", 32'(cmd_data_out), 32'h0);
    check_eq("rst_flags", 32'({init_done_out, pend_ovf_out, timeout_out, init_err_out,
                               cmd_done_out}), 32'h0);
    check_eq("rst_busy", 32'(busy_out), 32'd1);
    rst_in = 1'b0;

    // DAC reset pin released after 255 cycles
    n = 0;
    while (dac_rst_out && n < 400) begin
      @(posedge clk_in); #1;
      n++;
    end
    check_eq("dac_rst_cycles", 32'(n), 32'd255);

    // Wait for first init trigger, then queue three host commands
    n = 0;
    while (trig_cnt == 0 && n < 20) begin
      @(posedge clk_in); #1;
      n++;
    end
    check_eq("first_init_trig_seen", 32'(trig_cnt), 32'd1);
    send_cmd(16'h2105, 16'h0011);
    wait_cycles(1);
    check_eq("ovf_after_first", 32'(pend_ovf_out), 32'd0);
    send_cmd(16'h2106, 16'h0022);
    send_cmd(16'h2107, 16'h0033);
    wait_cycles(1);
    check_eq("ovf_after_third", 32'(pend_ovf_out), 32'd1);
    check_eq("no_init_done_yet", 32'(init_done_out), 32'd0);

    bring_up("init_done");
    check_eq("init_trig_cnt", 32'(trig_cnt), 32'(INIT_TRIGS));
    check_eq("model_idle_at_done", 32'(m_ready), 32'd1);
    for (int i = 0; i < INIT_TRIGS; i++)
      check_eq($sformatf("init_word%0d", i), 32'(log_at(i)), 32'(exp_init[i]));
    check_eq("init_err", 32'(init_err_out), 32'(EXP_INIT_ERR));
    check_eq("timeout_clear", 32'(timeout_out), 32'd0);

    // Queued command served after init; the two others dropped
    wait_done(0, 200, "queued_done");
    wait_cycles(40);
    check_eq("queued_word", 32'(log_at(INIT_TRIGS)), 32'h0511);
    check_eq("queued_only_one", 32'(trig_cnt), 32'(INIT_TRIGS + 1));
    check_eq("queued_done_cnt", 32'(done_cnt), 32'd1);
    check_eq("idle_after_queued", 32'(busy_out), 32'd0);

    // Host set in IDLE: latency, word, single pulses
    base = trig_log.size(); t0 = trig_cnt; d0 = done_cnt;
    send_cmd(16'h2105, 16'h0033);
    wait_done(d0, 200, "set_done");
    wait_cycles(5);
    check_eq("set_latency", 32'(last_trig_cyc - cmd_cyc), 32'd3);
    check_eq("set_word", 32'(log_at(base)), 32'h0533);
    check_eq("set_trig_pulses", 32'(trig_cnt - t0), 32'd1);
    check_eq("set_done_pulses", 32'(done_cnt - d0), 32'd1);

    // Host get
    rd_force = 1'b1; rd_val = 16'h00A7;
    base = trig_log.size(); d0 = done_cnt;
    send_cmd(16'h2005, 16'h1234);
    wait_done(d0, 200, "get_done");
    check_eq("get_word", 32'(log_at(base)), 32'h8500);
    check_eq("get_data", 32'(done_data), 32'h00A7);
    check_eq("get_data_held", 32'(cmd_data_out), 32'h00A7);
    rd_force = 1'b0;

    // Invalid opcode ignored
    t0 = trig_cnt; d0 = done_cnt;
    send_cmd(16'h3005, 16'h0099);
    wait_cycles(30);
    check_eq("invalid_no_trig", 32'(trig_cnt - t0), 32'd0);
    check_eq("invalid_no_done", 32'(done_cnt - d0), 32'd0);

    // Timeout: model never leaves ready
    stuck = 1'b1; d0 = done_cnt;
    send_cmd(16'h2106, 16'h0044);
    wait_done(d0, 1500, "timeout_done");
    check_eq("timeout_data", 32'(done_data), 32'h0000DEAD);
    check_eq("timeout_flag", 32'(timeout_out), 32'd1);
    wait_cycles(2);
    check_eq("timeout_idle", 32'(busy_out), 32'd0);
    stuck = 1'b0;

    // Recovery after timeout
    base = trig_log.size(); d0 = done_cnt;
    send_cmd(16'h2107, 16'h0055);
    wait_done(d0, 200, "recover_done");
    check_eq("recover_word", 32'(log_at(base)), 32'h0755);

    // Reset mid-operation
    send_cmd(16'h2108, 16'h0066);
    wait_cycles(6);
    @(negedge clk_in); rst_in = 1'b1;
    @(negedge clk_in);
    check_eq("midrst_dac", 32'(dac_rst_out), 32'd1);
    check_eq("midrst_cmd_data", 32'(cmd_data_out), 32'h0);
    check_eq("midrst_flags", 32'({init_done_out, pend_ovf_out, timeout_out}), 32'h0);
    check_eq("midrst_spi_data", 32'(spi_data_out), 32'h0);
    rst_in = 1'b0;
    bring_up("reinit_done");
    wait_cycles(5);

    // Trig on the cycle IDLE drains the slot is accepted
    base = trig_log.size(); d0 = done_cnt;
    @(negedge clk_in);
    cmd_trig_in = 1'b1; cmd_addr_in = 16'h2103; cmd_data_in = 16'h0001;
    @(negedge clk_in);
    cmd_addr_in = 16'h2104; cmd_data_in = 16'h0002;
    @(negedge clk_in);
    cmd_trig_in = 1'b0;
    wait_done(d0, 200, "drain_done1");
    wait_done(d0 + 1, 200, "drain_done2");
    check_eq("drain_no_ovf", 32'(pend_ovf_out), 32'd0);
    check_eq("drain_word1", 32'(log_at(base)), 32'h0301);
    check_eq("drain_word2", 32'(log_at(base + 1)), 32'h0402);
    check_eq("done_while_idle", 32'(done_busy), 32'd0);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1);
  end

endmodule
